// File: rtl/victim_writeback.sv
// Victim write-back engine: reads an evicted dirty block one word at a time from the
// selected cache way and streams it to memory as a burst of write beats.
module victim_writeback #(
  parameter int unsigned NUM_WAYS      = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE    = 32,
  parameter int unsigned WORD_WIDTH    = 32,
  localparam int unsigned WORDS        = BLOCK_SIZE * 8 / WORD_WIDTH,
  localparam int unsigned IDX_W        = $clog2(WORDS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           evict_valid,
  output logic                           evict_ready,
  input  logic [NUM_WAYS-1:0]            evict_target,
  input  logic                           evict_dirty,
  input  logic [ADDRESS_WIDTH-1:0]       evict_addr,
  output logic [NUM_WAYS-1:0]            way_rd_en,
  output logic [IDX_W-1:0]               way_rd_idx,
  input  logic [NUM_WAYS*WORD_WIDTH-1:0] way_rd_data,
  output logic                           mem_wr_valid,
  input  logic                           mem_wr_ready,
  output logic [ADDRESS_WIDTH-1:0]       mem_wr_addr,
  output logic [WORD_WIDTH-1:0]          mem_wr_data,
  output logic                           mem_wr_last,
  output logic                           wb_done,
  output logic                           wb_error
);

  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] OffMask = ADDRESS_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StRead, StCapture, StSend, StDone} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]    buf_q, buf_d;
  logic [NUM_WAYS-1:0]      target_q, target_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic                     error_q, error_d;
  logic [WORD_WIDTH-1:0]    sel_data;
  logic                     is_last;
  logic                     send;

  assign is_last = (cnt_q == IDX_W'(WORDS - 1));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (target_q[i]) sel_data |= way_rd_data[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // The clean/dirty decision is folded into the next state, so only the target is kept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    target_d = target_q;
    base_d   = base_q;
    error_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (evict_valid) begin
          target_d = evict_target;
          base_d   = evict_addr & ~OffMask;
          cnt_d    = '0;
          if (!$onehot(evict_target)) error_d = 1'b1;
          else if (evict_dirty)       state_d = StRead;
          else                        state_d = StDone;
        end
      end
      StRead:    state_d = StCapture;
      StCapture: begin
        buf_d   = sel_data;
        state_d = StSend;
      end
      StSend: begin
        if (mem_wr_ready) begin
          if (is_last) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = StRead;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      buf_q    <= '0;
      target_q <= '0;
      base_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      target_q <= target_d;
      base_q   <= base_d;
      error_q  <= error_d;
    end
  end

  // Outputs are decoded from registered state and forced low while reset is held.
  always_comb begin
    send         = !reset && (state_q == StSend);
    evict_ready  = !reset && (state_q == StIdle);
    way_rd_en    = (!reset && (state_q == StRead)) ? target_q : '0;
    way_rd_idx   = reset ? '0 : cnt_q;
    mem_wr_valid = send;
    mem_wr_addr  = send ? base_q + ADDRESS_WIDTH'(cnt_q) * ADDRESS_WIDTH'(WORD_BYTES) : '0;
    mem_wr_data  = send ? buf_q : '0;
    mem_wr_last  = send && is_last;
    wb_done      = !reset && (state_q == StDone);
    wb_error     = !reset && error_q;
  end

endmodule

// File: tb/tb_victim_writeback.sv
// Directed, table-driven bench for victim_writeback with a behavioural way-array model.
module tb_victim_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         evict_valid;
  logic         evict_ready;
  logic [3:0]   evict_target;
  logic         evict_dirty;
  logic [31:0]  evict_addr;
  logic [3:0]   way_rd_en;
  logic [2:0]   way_rd_idx;
  logic [127:0] way_rd_data;
  logic         mem_wr_valid;
  logic         mem_wr_ready;
  logic [31:0]  mem_wr_addr;
  logic [31:0]  mem_wr_data;
  logic         mem_wr_last;
  logic         wb_done;
  logic         wb_error;

  int n_cmp = 0;
  int n_bad = 0;

  victim_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .evict_valid  (evict_valid),
    .evict_ready  (evict_ready),
    .evict_target (evict_target),
    .evict_dirty  (evict_dirty),
    .evict_addr   (evict_addr),
    .way_rd_en    (way_rd_en),
    .way_rd_idx   (way_rd_idx),
    .way_rd_data  (way_rd_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_last  (mem_wr_last),
    .wb_done      (wb_done),
    .wb_error     (wb_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(int w, int i);
    return 32'hA000_0000 | (32'(w) << 16) | 32'(i);
  endfunction

  // Way arrays return data one cycle after the strobe; unstrobed ways return junk.
  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      way_rd_data[w*32 +: 32] <= way_rd_en[w] ? word_of(w, int'(way_rd_idx))
                                              : (32'hBAD0_0000 | 32'(w));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_evict(input logic [3:0] tgt, input logic dty, input logic [31:0] addr,
                           input int stall_beat, input int stall_len,
                           output int beats, output int reads, output int dones,
                           output int done_cyc, output int errs, output int rdy_cyc,
                           output int first_cyc);
    int w;
    int stall_left;
    logic [31:0] base;
    w = 0;
    for (int i = 0; i < 4; i++) if (tgt[i]) w = i;
    base = addr & ~32'h1F;
    beats = 0; reads = 0; dones = 0; errs = 0;
    done_cyc = -1; rdy_cyc = -1; first_cyc = -1;
    stall_left = stall_len;
    @(negedge clk);
    chk("accept_ready", {63'd0, evict_ready}, 64'd1);
    evict_valid = 1'b1; evict_target = tgt; evict_dirty = dty; evict_addr = addr;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      evict_valid = 1'b0;
      if (way_rd_en != 4'd0) begin
        reads++;
        chk("rd_en", {60'd0, way_rd_en}, {60'd0, tgt});
        chk("rd_idx", {61'd0, way_rd_idx}, 64'(beats));
      end
      if (wb_done) begin dones++; done_cyc = c; end
      if (wb_error) errs++;
      if (evict_ready && rdy_cyc < 0) rdy_cyc = c;
      mem_wr_ready = 1'b1;
      if (mem_wr_valid) begin
        if (first_cyc < 0) first_cyc = c;
        chk("beat_addr", {32'd0, mem_wr_addr}, {32'd0, base + 32'(beats * 4)});
        chk("beat_data", {32'd0, mem_wr_data}, {32'd0, word_of(w, beats)});
        chk("beat_last", {63'd0, mem_wr_last}, {63'd0, beats == 7});
        if (beats == stall_beat && stall_left > 0) begin
          mem_wr_ready = 1'b0;
          stall_left--;
        end else begin
          beats++;
        end
      end
    end
    mem_wr_ready = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  tgt;
    logic        dty;
    logic [31:0] addr;
    int          stall_beat;
    int          stall_len;
    int          exp_beats;
    int          exp_done;
    int          exp_err;
    int          exp_rdy;
    int          exp_first;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int beats, reads, dones, done_cyc, errs, rdy_cyc, first_cyc;
    int acc[4];
    int dn[4];
    int na, nd, hit, seen_done;

    vecs[0] = '{4'b0100, 1'b1, 32'h0000_1234, -1, 0, 8, 25,  0, 26,  3};
    vecs[1] = '{4'b0001, 1'b0, 32'h0000_0040, -1, 0, 0,  1,  0,  2, -1};
    vecs[2] = '{4'b0110, 1'b1, 32'h0000_0080, -1, 0, 0, -1,  1,  1, -1};
    vecs[3] = '{4'b0000, 1'b1, 32'h0000_0080, -1, 0, 0, -1,  1,  1, -1};
    vecs[4] = '{4'b1000, 1'b1, 32'hFFFF_FFE7, -1, 0, 8, 25,  0, 26,  3};
    vecs[5] = '{4'b0010, 1'b1, 32'h0000_0100,  3, 5, 8, 30,  0, 31,  3};
    vecs[6] = '{4'b0001, 1'b1, 32'h0000_0000,  7, 2, 8, 27,  0, 28,  3};
    vecs[7] = '{4'b1000, 1'b0, 32'h0000_5555, -1, 0, 0,  1,  0,  2, -1};

    reset = 1'b1; evict_valid = 1'b0; evict_target = 4'd0; evict_dirty = 1'b0;
    evict_addr = 32'd0; mem_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, evict_ready}, 64'd0);
    chk("rst_outs", {58'd0, way_rd_en, mem_wr_valid, mem_wr_last}, 64'd0);
    chk("rst_busses", {mem_wr_addr, mem_wr_data}, 64'd0);
    chk("rst_pulses", {61'd0, way_rd_idx != 3'd0, wb_done, wb_error}, 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_evict(vecs[v].tgt, vecs[v].dty, vecs[v].addr, vecs[v].stall_beat, vecs[v].stall_len,
                beats, reads, dones, done_cyc, errs, rdy_cyc, first_cyc);
      chk($sformatf("v%0d_beats", v), 64'(beats), 64'(vecs[v].exp_beats));
      chk($sformatf("v%0d_reads", v), 64'(reads), 64'(vecs[v].exp_beats));
      chk($sformatf("v%0d_done_cyc", v), 64'(done_cyc), 64'(vecs[v].exp_done));
      chk($sformatf("v%0d_dones", v), 64'(dones), 64'(vecs[v].exp_done < 0 ? 0 : 1));
      chk($sformatf("v%0d_errs", v), 64'(errs), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_ready_cyc", v), 64'(rdy_cyc), 64'(vecs[v].exp_rdy));
      chk($sformatf("v%0d_first_beat", v), 64'(first_cyc), 64'(vecs[v].exp_first));
    end

    // Reset asserted while the fifth beat (index 4) is in SEND.
    @(negedge clk);
    evict_valid = 1'b1; evict_target = 4'b0010; evict_dirty = 1'b1; evict_addr = 32'h2000;
    beats = 0; hit = 0; seen_done = 0;
    for (int c = 1; c <= 40 && hit == 0; c++) begin
      @(negedge clk);
      evict_valid = 1'b0;
      if (wb_done) seen_done = 1;
      if (mem_wr_valid) begin
        if (beats == 4) begin
          hit = 1;
          reset = 1'b1;
        end else begin
          beats++;
        end
      end
    end
    chk("rstmid_reached", 64'(hit), 64'd1);
    @(negedge clk);
    chk("rstmid_ready", {63'd0, evict_ready}, 64'd0);
    chk("rstmid_outs", {58'd0, way_rd_en, mem_wr_valid, mem_wr_last}, 64'd0);
    chk("rstmid_busses", {mem_wr_addr, mem_wr_data}, 64'd0);
    chk("rstmid_pulses", {61'd0, way_rd_idx != 3'd0, wb_done, wb_error}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    if (wb_done) seen_done = 1;
    chk("rstmid_no_done", 64'(seen_done), 64'd0);
    chk("rstmid_ready_after", {63'd0, evict_ready}, 64'd1);
    run_evict(4'b0010, 1'b1, 32'h2000, -1, 0, beats, reads, dones, done_cyc, errs, rdy_cyc,
              first_cyc);
    chk("rstmid_new_beats", 64'(beats), 64'd8);
    chk("rstmid_new_done", 64'(done_cyc), 64'd25);

    // evict_valid held high: one accept per transfer, next accept right after wb_done.
    @(negedge clk);
    evict_valid = 1'b1; evict_target = 4'b0100; evict_dirty = 1'b1; evict_addr = 32'h1234;
    na = 0; nd = 0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (wb_done && nd < 4) begin dn[nd] = c; nd++; end
      if (evict_valid && evict_ready && na < 4) begin acc[na] = c; na++; end
    end
    chk("hold_accepts", 64'(na), 64'd2);
    chk("hold_dones", 64'(nd), 64'd2);
    if (na >= 2 && nd >= 2) begin
      chk("hold_acc1", 64'(acc[0]), 64'd26);
      chk("hold_acc2", 64'(acc[1]), 64'd52);
      chk("hold_done1", 64'(dn[0]), 64'd25);
      chk("hold_done2", 64'(dn[1]), 64'd51);
    end
    evict_valid = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && hit == 0; c++) begin
      @(negedge clk);
      if (wb_done) hit = 1;
    end
    chk("hold_drain", 64'(hit), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/victim_writeback.md
VICTIM_WRITEBACK -- requirements
Module: victim_writeback

Interface
REQ-001 Parameter NUM_WAYS, default 4, number of cache ways; target vectors are one bit per way.
REQ-002 Parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-003 Parameter BLOCK_SIZE, default 32, block size in bytes (power of two).
REQ-004 Parameter WORD_WIDTH, default 32, memory-channel data width in bits; WORDS = BLOCK_SIZE*8/WORD_WIDTH, at least 2.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 evict_valid  input  1  eviction request present.
REQ-008 evict_ready  output  1  request accepted when evict_valid & evict_ready.
REQ-009 evict_target  input  NUM_WAYS  one-hot victim way.
REQ-010 evict_dirty  input  1  victim holds modified data.
REQ-011 evict_addr  input  ADDRESS_WIDTH  any byte address inside the victim block.
REQ-012 way_rd_en  output  NUM_WAYS  per-way read strobe.
REQ-013 way_rd_idx  output  clog2(WORDS)  word index being read.
REQ-014 way_rd_data  input  NUM_WAYS x WORD_WIDTH  per-way read data, valid one cycle after its strobe.
REQ-015 mem_wr_valid  output  1  write beat present.
REQ-016 mem_wr_ready  input  1  beat consumed when mem_wr_valid & mem_wr_ready.
REQ-017 mem_wr_addr  output  ADDRESS_WIDTH  beat byte address.
REQ-018 mem_wr_data  output  WORD_WIDTH  beat data.
REQ-019 mem_wr_last  output  1  final beat of block.
REQ-020 wb_done  output  1  one-cycle pulse when the eviction completes.
REQ-021 wb_error  output  1  one-cycle pulse when a request has a non-one-hot target.

Function
REQ-022 FSM states: IDLE, READ, CAPTURE, SEND, DONE.
REQ-023 evict_ready = 1 only in IDLE; no other state accepts a request.
REQ-024 On acceptance, the block latches target, dirty flag, and block base = evict_addr with the low clog2(BLOCK_SIZE) bits cleared; the word counter is cleared to 0.
REQ-025 Accepted request with a non-one-hot target (including zero): wb_error pulses the next cycle; the FSM stays in IDLE; no way read and no memory beat.
REQ-026 Accepted clean request (one-hot, evict_dirty=0): next state DONE; no way read and no memory beat.
REQ-027 Accepted dirty request (one-hot): next state READ.
REQ-028 READ (one cycle): way_rd_en equals the latched target; way_rd_idx equals the counter; next state CAPTURE.
REQ-029 CAPTURE (one cycle): the block registers the selected way's way_rd_data into the beat buffer; way_rd_en = 0; next state SEND.
REQ-030 SEND: mem_wr_valid = 1; mem_wr_data is the buffer; mem_wr_addr = base + counter*(WORD_WIDTH/8); mem_wr_last = (counter == WORDS-1).
REQ-031 While mem_wr_valid & !mem_wr_ready, mem_wr_addr, mem_wr_data and mem_wr_last are held stable and valid is not withdrawn.
REQ-032 SEND with ready and not last: the counter increments; next state READ.
REQ-033 SEND with ready and last: next state DONE; the counter does not wrap past WORDS-1.
REQ-034 DONE (one cycle): wb_done = 1; next state IDLE.
REQ-035 Minimum dirty latency: 3 cycles per beat with ready tied high; acceptance at cycle T gives the first beat at T+3 and wb_done at T+3*WORDS+1.
REQ-036 Outside READ, way_rd_en = 0; outside SEND, mem_wr_valid = 0 and mem_wr_last = 0.
REQ-037 evict_valid is ignored while busy; requests are neither queued nor dropped, because evict_ready is low.

Reset
REQ-038 While reset = 1, every clock edge sets the FSM to IDLE and clears the counter, buffer and latched request.
REQ-039 While reset = 1, outputs are evict_ready=0, way_rd_en=0, way_rd_idx=0, mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_last=0, wb_done=0, wb_error=0.
REQ-040 Reset mid-transfer abandons the block with no wb_done; the first cycle after reset deasserts is IDLE with evict_ready=1.

Verification
REQ-041 Dirty evict, target=4'b0100, addr=0x0000_1234, ready high -> 8 beats at addresses 0x1220,0x1224,...,0x123C; data equals way 2 words 0..7; last only on 0x123C; wb_done at T+25.
REQ-042 Clean evict, target=4'b0001 -> no way_rd_en, no mem_wr_valid; wb_done at T+1; evict_ready high at T+2.
REQ-043 Targets 4'b0110 and 4'b0000 -> wb_error pulses one cycle each; no reads, no beats, no wb_done.
REQ-044 Dirty evict with ready low 5 cycles on beat 3 -> valid held; addr, data and last unchanged across the stall; totals unchanged otherwise.
REQ-045 Reset asserted during beat 4 SEND -> next cycle all outputs 0; after release evict_ready=1; a new dirty evict starts from word 0.
REQ-046 evict_valid held high throughout a transfer -> exactly one accept per transfer, second accept in the cycle after wb_done.
